sm_accum_ctrl: RTL
==================

Name: sm_accum_ctrl

Overview:
Sequencer that accumulates a stream of LEN sign-magnitude operands into one sum through a single shared sign-magnitude adder datapath.
- Used by neuron units to form weighted sums: product stream in, one sign-magnitude sum out.
- Owns the FSM, beat counter, accumulator register and output handshake.

Parameters:
SIZE, 16, operand/result width incl. sign bit (MSB = sign, SIZE-1 magnitude bits)
COUNT_W, 8, width of length field; max beats = 2^COUNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin new accumulation; sampled only in IDLE
len  input  COUNT_W  number of operands; latched on accepted start
in_valid  input  1  operand valid
in_ready  output  1  controller accepts operand this cycle
in_data  input  SIZE  sign-magnitude operand
out_valid  output  1  sum valid; held until out_ready
out_ready  input  1  downstream accepts sum
out_data  output  SIZE  sign-magnitude sum
overflow  output  1  sticky magnitude overflow for current sum; valid with out_valid
busy  output  1  high in any state except IDLE

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n).
- Reset: state=IDLE; acc=0, count=0; in_ready=0, out_valid=0, out_data=0, overflow=0, busy=0.
- Reset mid-operation aborts the run with no output; partial sum discarded.
- States IDLE, ACC, DONE.
- IDLE, start=1, len!=0: latch len into count; clear acc and overflow; go to ACC.
- IDLE, start=1, len==0: go to DONE with out_data=0x0 (+0).
- start outside IDLE is ignored.
- ACC: in_ready=1 combinationally.
  - Beat accepted when in_valid & in_ready: acc <= acc (+) in_data; count decrements.
  - Beat where count==1: go to DONE.
- DONE: out_valid=1; out_data=acc and overflow held stable.
  - out_valid & out_ready: go to IDLE. No beat is accepted in DONE.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle. Minimum run is len+2 cycles from start to return to IDLE with out_ready tied high.
- Sign-magnitude add:
  - Equal signs: magnitudes add; sign kept.
  - Different signs: larger magnitude minus smaller; sign of the larger magnitude.
  - Equal magnitudes with opposite signs: result +0.
- Zero normalisation: any zero-magnitude result has sign=0; 0x8000 never appears on out_data.
- Overflow: same-sign add with carry out of bit SIZE-2 sets sticky overflow.
  - Magnitude wraps mod 2^(SIZE-1); sign kept.
- in_data of -0 (0x8000) is treated as +0.

Optional Feature:
SM_ACCUM_SATURATE_EN
- Defined: on magnitude overflow, magnitude clamps to all ones (0x7FFF/0xFFFF for SIZE=16) and stays clamped for subsequent same-sign beats. Opposite-sign beats subtract from the clamped value. overflow still sets.
- Undefined: wrap behaviour as above.

Decomposition:
Package sm_accum_pkg:
- State enum (IDLE, ACC, DONE).
- SIGN_BIT index constant.
- Constant mag_max = {SIZE-1{1'b1}}.
- Zero-normalise function.

Sub-module sm_add_comb:
- Purely combinational sign-magnitude adder, parameter SIZE.
- Outputs sum and carry.
- Instantiated once; the controller muxes acc/in_data onto it.

Test Plan:
1. len=3, beats 0x0003, 0x8005, 0x0001 -> out_data=0x8001 (-1), overflow=0, out_valid exactly 1 cycle after third beat.
2. len=2, beats 0x0007, 0x8007 -> out_data=0x0000 (not 0x8000), overflow=0.
3. len=2, beats 0x7FFF, 0x0001 -> without SM_ACCUM_SATURATE_EN out_data=0x0000, overflow=1; with it out_data=0x7FFF, overflow=1.
4. start with len=0 -> out_valid next cycle, out_data=0x0000, no in_ready asserted.
5. len=4, in_valid toggling 1/0, then out_ready low 5 cycles -> sum of beats correct, out_data stable while stalled, start pulses during DONE ignored, busy=1 until handshake.
6. len=4, rst_n low for 1 cycle after 2 beats -> next cycle IDLE, busy=0, out_valid=0, in_ready=0. New start, len=1, beat 0x8002 -> out_data=0x8002.

Source files
------------

// File: rtl/sm_accum_pkg.sv
// Shared types and helpers for the sign-magnitude accumulator slice.
// SM_SIZE, SIGN_BIT and MAG_MAX describe the default 16-bit build.
package sm_accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SM_SIZE  = 16;
   localparam int unsigned SIGN_BIT = SM_SIZE - 1;
   localparam logic [SM_SIZE-2:0] MAG_MAX = '1;

   // A zero magnitude always carries a positive sign, so -0 never escapes.
   function automatic logic sm_sign_norm(input logic sign, input logic mag_zero);
      return sign & ~mag_zero;
   endfunction

endpackage

// File: rtl/sm_add_comb.sv
// Combinational sign-magnitude adder. The carry output is the carry out of
// the magnitude add and is only raised for same-sign operands.
module sm_add_comb
   import sm_accum_pkg::*;
#(
   parameter int unsigned SIZE = SM_SIZE
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] sum,
   output logic            carry
);

   localparam int unsigned MW = SIZE - 1;

   logic [MW-1:0] ma;
   logic [MW-1:0] mb;
   logic [MW-1:0] mag;
   logic [MW:0]   add_w;
   logic          sign;

   // Same sign: add magnitudes. Opposite: larger minus smaller, larger's sign.
   always_comb begin
      ma    = a[MW-1:0];
      mb    = b[MW-1:0];
      add_w = {1'b0, ma} + {1'b0, mb};
      mag   = '0;
      sign  = 1'b0;
      carry = 1'b0;
      if (a[MW] == b[MW]) begin
         mag   = add_w[MW-1:0];
         sign  = a[MW];
         carry = add_w[MW];
      end else if (ma >= mb) begin
         mag  = ma - mb;
         sign = a[MW];
      end else begin
         mag  = mb - ma;
         sign = b[MW];
      end
      sum = {sm_sign_norm(sign, mag == '0), mag};
   end

endmodule

// File: rtl/sm_accum_ctrl.sv
// Sign-magnitude stream accumulator: IDLE -> ACC (LEN beats) -> DONE.
// Optional build macro SM_ACCUM_SATURATE_EN clamps the magnitude on overflow
// instead of wrapping.
module sm_accum_ctrl
   import sm_accum_pkg::*;
#(
   parameter int unsigned SIZE    = SM_SIZE,
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SIZE-1:0]    in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SIZE-1:0]    out_data,
   output logic               overflow,
   output logic               busy
);

   localparam int unsigned SB = SIZE - 1;

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [SIZE-1:0]    acc_q, acc_d;
   logic               ovf_q, ovf_d;

   logic [SIZE-1:0]    in_norm;
   logic [SIZE-1:0]    add_sum;
   logic [SIZE-1:0]    beat_sum;
   logic               add_carry;

   // Treat an incoming -0 as +0 before it reaches the adder.
   always_comb begin
      in_norm = {sm_sign_norm(in_data[SB], in_data[SB-1:0] == '0), in_data[SB-1:0]};
   end

   sm_add_comb #(.SIZE(SIZE)) u_add (
      .a     (acc_q),
      .b     (in_norm),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // Overflow handling of the adder result: clamp or wrap.
   always_comb begin
      beat_sum = add_sum;
`ifdef SM_ACCUM_SATURATE_EN
      // Carry implies equal, non-zero-total operands, so in_norm holds the sign.
      if (add_carry) begin
         beat_sum = {in_norm[SB], {(SIZE-1){1'b1}}};
      end
`endif
   end

   // State, counter, accumulator and overflow registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               count_d = len;
               state_d = (len == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d   = beat_sum;
               ovf_d   = ovf_q | add_carry;
               count_d = count_q - 1'b1;
               if (count_q == COUNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data = acc_q;
   assign overflow = ovf_q;

endmodule
